// File: rtl/fpnew_result_reorder_pkg.sv
// rtl/fpnew_result_reorder_pkg.sv - shared types and constants for the FPU result reorder buffer
package fpnew_result_reorder_pkg;

    localparam int unsigned ROB_DEFAULT_DEPTH = 8;
    localparam int unsigned STATUS_WIDTH      = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpnew_result_reorder_if.sv
// rtl/fpnew_result_reorder_if.sv - alloc / writeback / retire bundle between dispatcher, opgroups and the reorder buffer
interface fpnew_result_reorder_if
    import fpnew_result_reorder_pkg::*;
#(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned Depth       = ROB_DEFAULT_DEPTH,
    parameter int unsigned Width       = 32,
    parameter int unsigned TagWidth    = 1
);
    localparam int unsigned IdWidth  = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic                                        flush_i;
    logic                                        alloc_valid_i;
    logic                                        alloc_ready_o;
    logic [TagWidth-1:0]                         alloc_tag_i;
    logic [IdWidth-1:0]                          alloc_id_o;
    logic [NumChannels-1:0]                      wb_valid_i;
    logic [NumChannels-1:0][IdWidth-1:0]         wb_id_i;
    logic [NumChannels-1:0][Width-1:0]           wb_result_i;
    logic [NumChannels-1:0][STATUS_WIDTH-1:0]    wb_status_i;
    logic [NumChannels-1:0]                      wb_ready_o;
    logic                                        out_valid_o;
    logic                                        out_ready_i;
    logic [Width-1:0]                            result_o;
    logic [STATUS_WIDTH-1:0]                     status_o;
    logic [TagWidth-1:0]                         tag_o;
    logic [CntWidth-1:0]                         count_o;
    logic                                        busy_o;
    logic                                        err_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_tag_i,
        output wb_valid_i, wb_id_i, wb_result_i, wb_status_i, out_ready_i,
        input  alloc_ready_o, alloc_id_o, wb_ready_o, out_valid_o,
        input  result_o, status_o, tag_o, count_o, busy_o, err_o
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_tag_i,
        input  wb_valid_i, wb_id_i, wb_result_i, wb_status_i, out_ready_i,
        output alloc_ready_o, alloc_id_o, wb_ready_o, out_valid_o,
        output result_o, status_o, tag_o, count_o, busy_o, err_o
    );

endinterface

// File: rtl/fpnew_result_reorder_rob_ptr.sv
// rtl/fpnew_result_reorder_rob_ptr.sv - wrap-bit pointer counter used for the buffer head and tail
module fpnew_rob_ptr #(
    parameter int unsigned IdWidth = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [IdWidth-1:0] ptr_o,
    output logic               wrap_o
);

    // Depth is a power of two, so the natural binary rollover toggles the wrap bit.
    logic [IdWidth:0] r_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr_o  = r_ptr[IdWidth-1:0];
    assign wrap_o = r_ptr[IdWidth];

endmodule

// File: rtl/fpnew_result_reorder.sv
// rtl/fpnew_result_reorder.sv - in-order completion buffer retiring multi-latency FPU results in issue order
module fpnew_result_reorder
    import fpnew_result_reorder_pkg::*;
#(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned Depth       = ROB_DEFAULT_DEPTH,
    parameter int unsigned Width       = 32,
    parameter int unsigned TagWidth    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fpnew_result_reorder_if.slave bus
);

    localparam int unsigned IdWidth  = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef struct packed {
        logic                alloc;
        logic                done;
        logic [Width-1:0]    result;
        status_t             status;
        logic [TagWidth-1:0] tag;
    } rob_entry_t;

    rob_entry_t             r_entries [Depth];
    logic                   r_err;

    logic [IdWidth-1:0]     w_head;
    logic [IdWidth-1:0]     w_tail;
    logic                   w_head_wrap;
    logic                   w_tail_wrap;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_alloc_ready;
    logic                   w_alloc_fire;
    logic                   w_out_valid;
    logic                   w_retire_fire;
    logic [CntWidth-1:0]    w_count;
    logic [NumChannels-1:0] w_wb_take;
    logic                   w_wb_err;

    fpnew_rob_ptr #(.IdWidth(IdWidth)) u_head_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (bus.flush_i),
        .inc_i   (w_retire_fire),
        .ptr_o   (w_head),
        .wrap_o  (w_head_wrap)
    );

    fpnew_rob_ptr #(.IdWidth(IdWidth)) u_tail_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (bus.flush_i),
        .inc_i   (w_alloc_fire),
        .ptr_o   (w_tail),
        .wrap_o  (w_tail_wrap)
    );

    assign w_empty       = (w_head == w_tail) && (w_head_wrap == w_tail_wrap);
    assign w_full        = (w_head == w_tail) && (w_head_wrap != w_tail_wrap);
    assign w_count       = CntWidth'({w_tail_wrap, w_tail} - {w_head_wrap, w_head});
    assign w_alloc_ready = !w_full && !rst_i;
    assign w_alloc_fire  = bus.alloc_valid_i && w_alloc_ready && !bus.flush_i;
    assign w_out_valid   = !w_empty && r_entries[w_head].done;
    assign w_retire_fire = w_out_valid && bus.out_ready_i && !bus.flush_i;

    // Lowest channel claims a slot first; any later hit on a claimed, free or finished slot is a protocol error.
    always_comb begin
        logic [Depth-1:0]   claimed;
        logic [IdWidth-1:0] id;
        w_wb_take = '0;
        w_wb_err  = 1'b0;
        claimed   = '0;
        id        = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (bus.wb_valid_i[c]) begin
                id = bus.wb_id_i[c];
                if (claimed[id] || !r_entries[id].alloc || r_entries[id].done) begin
                    w_wb_err = 1'b1;
                end else begin
                    w_wb_take[c] = 1'b1;
                    claimed[id]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_entries[i] <= '0;
            end
            r_err <= 1'b0;
        end else if (bus.flush_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_entries[i].alloc <= 1'b0;
                r_entries[i].done  <= 1'b0;
            end
        end else begin
            if (w_alloc_fire) begin
                r_entries[w_tail].alloc <= 1'b1;
                r_entries[w_tail].done  <= 1'b0;
                r_entries[w_tail].tag   <= bus.alloc_tag_i;
            end
            for (int c = 0; c < NumChannels; c++) begin
                if (w_wb_take[c]) begin
                    r_entries[bus.wb_id_i[c]].result <= bus.wb_result_i[c];
                    r_entries[bus.wb_id_i[c]].status <= bus.wb_status_i[c];
                    r_entries[bus.wb_id_i[c]].done   <= 1'b1;
                end
            end
            if (w_retire_fire) begin
                r_entries[w_head].alloc <= 1'b0;
                r_entries[w_head].done  <= 1'b0;
            end
            r_err <= r_err | w_wb_err;
        end
    end

    assign bus.alloc_ready_o = w_alloc_ready;
    assign bus.alloc_id_o    = w_tail;
    assign bus.wb_ready_o    = {NumChannels{!rst_i}};
    assign bus.out_valid_o   = w_out_valid;
    assign bus.result_o      = r_entries[w_head].result;
    assign bus.status_o      = r_entries[w_head].status;
    assign bus.tag_o         = r_entries[w_head].tag;
    assign bus.count_o       = w_count;
    assign bus.busy_o        = (w_count != '0);
    assign bus.err_o         = r_err;

endmodule
